register_file_multiport: RTL and testbench
==========================================

Name: register_file_multiport

Overview:
- Parametrised general-purpose register file built from enable-gated storage words.
- One write port with per-byte strobes; NUM_READ combinational read ports.
- Register 0 is hardwired to zero. One designated register, the stack pointer, has a programmable reset value.
- Sits between instruction decode and the ALU/writeback path of the single-cycle/pipelined RISC-V datapath.

Parameters:
- N, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; power of 2, at least 2.
- AW, $clog2(DEPTH), address width; derived, do not override.
- NUM_READ, 2, number of independent read ports, 1..4.
- SP_INDEX, 2, index of the register with a non-zero reset value.
- SP_RESET, 32'h7FFF_EFFC, reset value of register SP_INDEX, truncated to N bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-high
- RegWrite  in  1  write enable, sampled on posedge clk
- WriteRegister  in  AW  write address
- WriteData  in  N  write data
- WriteStrobe  in  N/8  byte-lane enables; bit k covers WriteData[8k+7:8k]
- ReadRegister  in  NUM_READ*AW  packed read addresses; port p uses bits [p*AW +: AW]
- ReadData  out  NUM_READ*N  packed read data; port p drives bits [p*N +: N]

Behaviour:
- Reset:
  - While reset=1, asynchronously: every register = 0, except register SP_INDEX = SP_RESET.
  - ReadData reflects the reset contents combinationally while reset is held.
  - Reset asserted mid-write wins; the write is discarded.
  - Deassertion is synchronised externally; the first write is accepted on the first posedge with reset=0.
- Write:
  - On posedge clk with reset=0, RegWrite=1 and WriteRegister!=0: each byte lane k with WriteStrobe[k]=1 is updated from WriteData.
  - Lanes with strobe 0 hold their value.
  - RegWrite=0 or WriteStrobe all-zero: no state change.
- Register 0:
  - Writes are ignored and no storage is allocated.
  - Reads return 0 always, including when SP_INDEX=0 is misconfigured; register 0 wins.
- Read:
  - Purely combinational, zero-cycle latency. ReadData[p] = contents of register ReadRegister[p].
  - Any number of ports may address the same register simultaneously.
  - Without bypass, a read of the register being written returns the pre-edge value until the edge, then the new value.
- Address range:
  - Addresses are AW bits wide and DEPTH is a power of 2, so there is no out-of-range case and no wrap logic.
- Simultaneous events: a write and any number of reads to the same index in one cycle are legal; the result is defined under Optional Feature.
- Widths:
  - No arithmetic. SP_RESET is zero-extended or truncated to N.
  - The N/8 strobe count is exact because N%8==0; elaboration fails otherwise via a generate-time check.

Optional Feature:
- Macro REGFILE_WRITE_BYPASS_EN.
- When defined:
  - If RegWrite=1, WriteRegister=ReadRegister[p] and the address is non-zero, ReadData[p] returns the merged value in the same cycle.
  - Merged value: strobed lanes come from WriteData, unstrobed lanes from stored contents.
  - This removes the writeback-to-decode hazard in the 5-stage pipeline.
  - Bypass is suppressed while reset=1.
- When undefined: no forwarding path; reads always show stored contents.

Test Plan:
- Reset check: assert reset=1 for 3 cycles, N=32, DEPTH=32 -> all ReadData=0 except reads of x2 return 32'h7FFF_EFFC; release reset -> values unchanged.
- Full-word write: write 32'hDEAD_BEEF to x5 with WriteStrobe=4'hF, read x5 on port 0 and port 1 next cycle -> both return 32'hDEAD_BEEF.
- Byte strobe: x5=32'hDEAD_BEEF, write 32'h1122_3344 with WriteStrobe=4'b0101 -> x5 reads 32'hDE22_BE44.
- Zero register: write 32'hFFFF_FFFF to x0 with strobe 4'hF -> x0 reads 0 on all ports. Also run with SP_INDEX=0 -> x0 reads 0 after reset.
- Same-cycle read/write to x7 (old value 32'h0000_0001, write 32'hABCD_0000, strobe 4'b1100):
  - Bypass defined -> ReadData returns 32'hABCD_0001 before the edge.
  - Bypass undefined -> returns 32'h0000_0001 before the edge, 32'hABCD_0001 after it.
- Reset mid-operation: RegWrite=1 to x9 with reset pulsed high between edges -> x9=0 after reset, no write committed; NUM_READ=4 all ports read x2 -> 32'h7FFF_EFFC.

Source files
------------

// File: rtl/register_file_multiport.sv
// Multiport register file: one byte-strobed write port, NUM_READ combinational read ports,
// x0 hardwired to zero, and a stack-pointer register with a programmable reset value.
// Optional same-cycle write-to-read forwarding when REGFILE_WRITE_BYPASS_EN is defined.
module register_file_multiport #(
  parameter int          N        = 32,
  parameter int          DEPTH    = 32,
  parameter int          AW       = $clog2(DEPTH),
  parameter int          NUM_READ = 2,
  parameter int          SP_INDEX = 2,
  parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RegWrite,
  input  logic [AW-1:0]          WriteRegister,
  input  logic [N-1:0]           WriteData,
  input  logic [N/8-1:0]         WriteStrobe,
  input  logic [NUM_READ*AW-1:0] ReadRegister,
  output logic [NUM_READ*N-1:0]  ReadData
);

  localparam int NB = N / 8;
  localparam logic [N-1:0] SP_VAL = N'(SP_RESET);

  if (N % 8 != 0) begin : g_bad_width
    $error("register_file_multiport: N must be a multiple of 8");
  end
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("register_file_multiport: DEPTH must be a power of 2 and at least 2");
  end
  if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_ports
    $error("register_file_multiport: NUM_READ must be in 1..4");
  end

  logic [N-1:0] mem [DEPTH];

  // x0 has no storage; it wins even if SP_INDEX is set to 0.
  assign mem[0] = '0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_reg
    localparam logic [N-1:0] RST_VAL = (r == SP_INDEX) ? SP_VAL : '0;
    logic         hit;
    logic [N-1:0] word;

    assign hit = RegWrite && (WriteRegister == AW'(r));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word <= RST_VAL;
      end else begin
        for (int k = 0; k < NB; k++) begin
          if (hit && WriteStrobe[k]) begin
            word[8*k +: 8] <= WriteData[8*k +: 8];
          end
        end
      end
    end

    assign mem[r] = word;
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    logic [AW-1:0] addr;
    logic [N-1:0]  data;

    assign addr = ReadRegister[p*AW +: AW];

    always_comb begin
      data = mem[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
      // Forward strobed lanes of an in-flight write so decode sees writeback this cycle.
      if (!reset && RegWrite && (WriteRegister == addr) && (addr != '0)) begin
        for (int k = 0; k < NB; k++) begin
          if (WriteStrobe[k]) begin
            data[8*k +: 8] = WriteData[8*k +: 8];
          end
        end
      end
`endif
    end

    assign ReadData[p*N +: N] = data;
  end

endmodule

// File: tb/tb_register_file_multiport.sv
// Self-checking bench for register_file_multiport: table-driven write/read vectors through
// an expected-value queue, plus hand-written reset, same-cycle and mid-write-reset sequences.
module tb_register_file_multiport;

  logic         clk = 1'b0;
  logic         reset;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [31:0]  WriteData;
  logic [3:0]   WriteStrobe;
  logic [9:0]   rr2;
  logic [63:0]  rd2;
  logic [19:0]  rr4;
  logic [127:0] rd4;
  logic [4:0]   rr1;
  logic [31:0]  rd1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  register_file_multiport dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .WriteStrobe(WriteStrobe), .ReadRegister(rr2), .ReadData(rd2)
  );

  register_file_multiport #(.NUM_READ(4)) dut4 (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .WriteStrobe(WriteStrobe), .ReadRegister(rr4), .ReadData(rd4)
  );

  register_file_multiport #(.NUM_READ(1), .SP_INDEX(0)) dut0 (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .WriteStrobe(WriteStrobe), .ReadRegister(rr1), .ReadData(rd1)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [31:0] act);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %h, expected queue empty", name, act);
    end else begin
      check(name, act, sb.pop_front());
    end
  endtask

  task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1);
    rr2 = {a1, a0};
    rr4 = {a1, a0, a1, a0};
    rr1 = a1;
  endtask

  initial begin
    reset = 1'b1;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    WriteStrobe = '0;
    set_reads(5'd2, 5'd0);

    vecs[0] = '{1'b0, 5'd0,  32'h0000_0000, 4'h0, 5'd0,  5'd2,  32'h0000_0000, 32'h7FFF_EFFC};
    vecs[1] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 4'hF, 5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd5,  32'h1122_3344, 4'h5, 5'd5,  5'd2,  32'hDE22_BE44, 32'h7FFF_EFFC};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 4'hF, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{1'b1, 5'd7,  32'h0000_0001, 4'hF, 5'd7,  5'd5,  32'h0000_0001, 32'hDE22_BE44};
    vecs[5] = '{1'b0, 5'd7,  32'hFFFF_FFFF, 4'hF, 5'd7,  5'd0,  32'h0000_0001, 32'h0000_0000};
    vecs[6] = '{1'b1, 5'd8,  32'hFFFF_FFFF, 4'h0, 5'd8,  5'd7,  32'h0000_0000, 32'h0000_0001};
    vecs[7] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 4'h2, 5'd31, 5'd30, 32'h0000_A500, 32'h0000_0000};
    vecs[8] = '{1'b1, 5'd2,  32'h1234_5678, 4'h8, 5'd2,  5'd31, 32'h12FF_EFFC, 32'h0000_A500};

    // Reset held for three cycles: contents visible combinationally.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x2_p0", rd2[31:0], 32'h7FFF_EFFC);
    check("rst_x0_p1", rd2[63:32], 32'h0);
    for (int p = 0; p < 4; p++)
      check($sformatf("rst_nr4_p%0d", p), rd4[p*32 +: 32], (p % 2 == 0) ? 32'h7FFF_EFFC : 32'h0);
    check("rst_sp0_x0", rd1, 32'h0);
    reset = 1'b0;
    #1;
    check("rel_x2_p0", rd2[31:0], 32'h7FFF_EFFC);
    check("rel_x0_p1", rd2[63:32], 32'h0);
    rr1 = 5'd2;
    #1;
    check("rel_sp0_x2", rd1, 32'h0);

    // Table vectors: write on the edge, read back just after it.
    foreach (vecs[i]) begin
      @(negedge clk);
      RegWrite = vecs[i].we;
      WriteRegister = vecs[i].wreg;
      WriteData = vecs[i].wdata;
      WriteStrobe = vecs[i].wstrb;
      set_reads(vecs[i].ra0, vecs[i].ra1);
      sb.push_back(vecs[i].e0);
      sb.push_back(vecs[i].e1);
      for (int p = 0; p < 4; p++) sb.push_back((p % 2 == 0) ? vecs[i].e0 : vecs[i].e1);
      @(posedge clk);
      #1;
      pop_check($sformatf("vec%0d_p0", i), rd2[31:0]);
      pop_check($sformatf("vec%0d_p1", i), rd2[63:32]);
      for (int p = 0; p < 4; p++) pop_check($sformatf("vec%0d_nr4_p%0d", i, p), rd4[p*32 +: 32]);
    end
    @(negedge clk);
    RegWrite = 1'b0;

    // Same-cycle read and write of x7 (stored value 1).
    @(negedge clk);
    RegWrite = 1'b1;
    WriteRegister = 5'd7;
    WriteData = 32'hABCD_0000;
    WriteStrobe = 4'b1100;
    set_reads(5'd7, 5'd7);
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("samecyc_pre_p0", rd2[31:0], 32'hABCD_0001);
    check("samecyc_pre_p1", rd2[63:32], 32'hABCD_0001);
`else
    check("samecyc_pre_p0", rd2[31:0], 32'h0000_0001);
    check("samecyc_pre_p1", rd2[63:32], 32'h0000_0001);
`endif
    @(posedge clk);
    #1;
    check("samecyc_post_p0", rd2[31:0], 32'hABCD_0001);
    check("samecyc_post_p1", rd2[63:32], 32'hABCD_0001);

    // Reset raised while a write to x9 is pending: the write is discarded.
    @(negedge clk);
    WriteRegister = 5'd9;
    WriteData = 32'h55AA_55AA;
    WriteStrobe = 4'hF;
    set_reads(5'd9, 5'd9);
    @(posedge clk);
    #1;
    check("x9_write", rd2[31:0], 32'h55AA_55AA);
    @(negedge clk);
    WriteData = 32'h0F0F_0F0F;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_async_x9", rd2[31:0], 32'h0);
    check("midrst_async_x9_p1", rd2[63:32], 32'h0);
    @(posedge clk);
    #1;
    check("midrst_edge_x9", rd2[31:0], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    RegWrite = 1'b0;
    #1;
    check("midrst_rel_x9", rd2[31:0], 32'h0);
    set_reads(5'd2, 5'd2);
    #1;
    for (int p = 0; p < 4; p++) check($sformatf("midrst_nr4_x2_p%0d", p), rd4[p*32 +: 32], 32'h7FFF_EFFC);
    check("midrst_sp0_x2", rd1, 32'h0);
    set_reads(5'd5, 5'd7);
    #1;
    check("midrst_x5", rd2[31:0], 32'h0);
    check("midrst_x7", rd2[63:32], 32'h0);
    @(posedge clk);
    #1;
    check("midrst_hold_x5", rd2[31:0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
